// File: rtl/packet_injector.sv
// ----------------------------------------------------------------------------
// noc_params : shared NoC widths and the flit_t link format.
// packet_injector : node-side packetizer feeding a router LOCAL input port.
//   A request (dest, length) becomes one HEADTAIL flit, or a HEAD flit followed
//   by BODY flits and a closing TAIL flit. Each body/tail flit carries one
//   payload word. Packets are assigned round-robin to the VCs that are
//   currently on, and a packet stays on its VC until the TAIL.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   pkt_valid_i/pkt_ready_o          packet request handshake
//   x_dest_i, y_dest_i, pkt_len_i    request fields, sampled at accept
//   payload_valid_i/payload_ready_o  body/tail payload word handshake
//   payload_i                        payload word
//   on_off_i                         per-VC on/off from downstream (1 = may send)
//   data_o, valid_flit_o             registered flit output
//   flits_sent_o, stall_cycles_o     statistics, only with INJECTOR_STATS_EN
//
// Build option: define INJECTOR_STATS_EN to add the two wrapping statistics
// counters. Without it the ports and counters do not exist.
// ----------------------------------------------------------------------------
package noc_params;
  localparam int VC_NUM            = 2;
  localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DEST_ADDR_SIZE_X  = 4;
  localparam int DEST_ADDR_SIZE_Y  = 4;
  localparam int FLIT_DATA_SIZE    = 16;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

module packet_injector
  import noc_params::*;
#(
  parameter int MAX_PKT_LEN = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pkt_valid_i,
  output logic                               pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0]        x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0]        y_dest_i,
  input  logic [$clog2(MAX_PKT_LEN+1)-1:0]   pkt_len_i,
  input  logic                               payload_valid_i,
  input  logic [FLIT_DATA_SIZE-1:0]          payload_i,
  output logic                               payload_ready_o,
  input  logic [VC_NUM-1:0]                  on_off_i,
  output flit_t                              data_o,
`ifdef INJECTOR_STATS_EN
  output logic [31:0]                        flits_sent_o,
  output logic [31:0]                        stall_cycles_o,
`endif
  output logic                               valid_flit_o
);

  localparam int LEN_W = $clog2(MAX_PKT_LEN+1);

  typedef enum logic {ST_IDLE, ST_BODY} state_t;

  state_t             state_q, state_d;
  logic [VC_SIZE-1:0] rr_ptr_q, rr_ptr_d;
  logic [VC_SIZE-1:0] cur_vc_q, cur_vc_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   len_clip;
  logic [VC_SIZE-1:0] vc_choice;
  logic [VC_SIZE-1:0] probe_vc;
  logic               vc_found;
  logic               issue_d;
  flit_t              flit_d;

  // First VC with on_off set, scanning upward from rr_ptr and wrapping.
  always_comb begin
    vc_choice = rr_ptr_q;
    probe_vc  = rr_ptr_q;
    vc_found  = 1'b0;
    for (int i = 0; i < VC_NUM; i++) begin
      probe_vc = (int'(rr_ptr_q) + i >= VC_NUM) ? VC_SIZE'(int'(rr_ptr_q) + i - VC_NUM)
                                                : VC_SIZE'(int'(rr_ptr_q) + i);
      if (!vc_found && on_off_i[probe_vc]) begin
        vc_found  = 1'b1;
        vc_choice = probe_vc;
      end
    end
  end

  always_comb begin
    len_clip = pkt_len_i;
    if (pkt_len_i == '0)
      len_clip = LEN_W'(1);
    else if (pkt_len_i > LEN_W'(MAX_PKT_LEN))
      len_clip = LEN_W'(MAX_PKT_LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Ready outputs are held low while rst is asserted so nothing handshakes
  // against a design that is being cleared.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    cur_vc_d        = cur_vc_q;
    remaining_d     = remaining_q;
    pkt_ready_o     = 1'b0;
    payload_ready_o = 1'b0;
    issue_d         = 1'b0;
    flit_d          = '0;
    case (state_q)
      ST_IDLE: begin
        pkt_ready_o = (|on_off_i) & ~rst;
        if (pkt_valid_i && pkt_ready_o) begin
          cur_vc_d                     = vc_choice;
          rr_ptr_d                     = (int'(vc_choice) == VC_NUM-1) ? '0 : vc_choice + VC_SIZE'(1);
          issue_d                      = 1'b1;
          flit_d.vc_id                 = vc_choice;
          flit_d.data.head_data.x_dest = x_dest_i;
          flit_d.data.head_data.y_dest = y_dest_i;
          if (len_clip == LEN_W'(1)) begin
            flit_d.flit_label = HEADTAIL;
          end else begin
            flit_d.flit_label = HEAD;
            remaining_d       = len_clip - LEN_W'(1);
            state_d           = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        payload_ready_o = on_off_i[cur_vc_q] & ~rst;
        if (payload_valid_i && payload_ready_o) begin
          issue_d          = 1'b1;
          flit_d.vc_id     = cur_vc_q;
          flit_d.data.bt_pl = payload_i;
          remaining_d      = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            flit_d.flit_label = TAIL;
            state_d           = ST_IDLE;
          end else begin
            flit_d.flit_label = BODY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      cur_vc_q     <= '0;
      remaining_q  <= '0;
      valid_flit_o <= 1'b0;
      data_o       <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cur_vc_q     <= cur_vc_d;
      remaining_q  <= remaining_d;
      valid_flit_o <= issue_d;
      if (issue_d) data_o <= flit_d;
    end
  end

`ifdef INJECTOR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flits_sent_o   <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (valid_flit_o)
        flits_sent_o <= flits_sent_o + 32'd1;
      if (state_q == ST_BODY && payload_valid_i && !on_off_i[cur_vc_q])
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packet_injector.sv
module tb_packet_injector;
  import noc_params::*;

  localparam int MAXL = 8;
  localparam int LW   = $clog2(MAXL+1);

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        pkt_valid;
  logic                        pkt_ready;
  logic [DEST_ADDR_SIZE_X-1:0] x_dest;
  logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
  logic [LW-1:0]               pkt_len;
  logic                        payload_valid;
  logic [FLIT_DATA_SIZE-1:0]   payload;
  logic                        payload_ready;
  logic [VC_NUM-1:0]           on_off;
  flit_t                       data;
  logic                        valid_flit;
`ifdef INJECTOR_STATS_EN
  logic [31:0]                 flits_sent;
  logic [31:0]                 stall_cycles;
`endif

  packet_injector #(.MAX_PKT_LEN(MAXL)) dut (
    .clk             (clk),
    .rst             (rst),
    .pkt_valid_i     (pkt_valid),
    .pkt_ready_o     (pkt_ready),
    .x_dest_i        (x_dest),
    .y_dest_i        (y_dest),
    .pkt_len_i       (pkt_len),
    .payload_valid_i (payload_valid),
    .payload_i       (payload),
    .payload_ready_o (payload_ready),
    .on_off_i        (on_off),
    .data_o          (data),
`ifdef INJECTOR_STATS_EN
    .flits_sent_o    (flits_sent),
    .stall_cycles_o  (stall_cycles),
`endif
    .valid_flit_o    (valid_flit)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              pv;
    int                x, y, len;
    logic              plv;
    logic [15:0]       pl;
    logic [VC_NUM-1:0] on;
    logic              e_pr, e_plr, e_v;
    flit_t             e_f;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic flit_t mk_head(input flit_label_t l, input int vc, input int x, input int y);
    flit_t f;
    f = '0;
    f.flit_label = l;
    f.vc_id = VC_SIZE'(vc);
    f.data.head_data.x_dest = DEST_ADDR_SIZE_X'(x);
    f.data.head_data.y_dest = DEST_ADDR_SIZE_Y'(y);
    return f;
  endfunction

  function automatic flit_t mk_bt(input flit_label_t l, input int vc, input logic [15:0] pl);
    flit_t f;
    f = '0;
    f.flit_label = l;
    f.vc_id = VC_SIZE'(vc);
    f.data.bt_pl = pl;
    return f;
  endfunction

  task automatic add(input logic pv, input int x, input int y, input int len,
                     input logic plv, input logic [15:0] pl, input logic [VC_NUM-1:0] on,
                     input logic e_pr, input logic e_plr, input logic e_v, input flit_t e_f);
    vec_t v;
    v.pv = pv; v.x = x; v.y = y; v.len = len; v.plv = plv; v.pl = pl; v.on = on;
    v.e_pr = e_pr; v.e_plr = e_plr; v.e_v = e_v; v.e_f = e_f;
    tbl.push_back(v);
  endtask

  // Entered just after a falling edge: drive, check readies, clock, check flit.
  task automatic run_cycle(input string tag, input vec_t v);
    pkt_valid     = v.pv;
    x_dest        = DEST_ADDR_SIZE_X'(v.x);
    y_dest        = DEST_ADDR_SIZE_Y'(v.y);
    pkt_len       = LW'(v.len);
    payload_valid = v.plv;
    payload       = v.pl;
    on_off        = v.on;
    #1;
    chk({tag, "_pkt_ready"}, 64'(pkt_ready), 64'(v.e_pr));
    chk({tag, "_payload_ready"}, 64'(payload_ready), 64'(v.e_plr));
    @(posedge clk);
    #1;
    chk({tag, "_valid_flit"}, 64'(valid_flit), 64'(v.e_v));
    if (v.e_v) chk({tag, "_flit"}, 64'(data), 64'(v.e_f));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pkt_valid = 1'b0; payload_valid = 1'b0; on_off = '1;
    x_dest = '0; y_dest = '0; pkt_len = '0; payload = '0;
    #1;
    chk("reset_valid_flit", 64'(valid_flit), 64'd0);
    chk("reset_data", 64'(data), 64'd0);
    chk("reset_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("reset_payload_ready", 64'(payload_ready), 64'd0);
`ifdef INJECTOR_STATS_EN
    chk("reset_flits_sent", 64'(flits_sent), 64'd0);
    chk("reset_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    flit_t f0;
    vec_t  v;
    int    m_rem, m_vc, m_rr, m_sent, m_stall;
    f0 = '0;

    // T1 single flit, T2 five flits, T3 back-pressure, T4 rotation, T5 clipping.
    add(1, 2, 3, 1,  0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEADTAIL, 0, 2, 3));
    add(1, 1, 1, 5,  0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEAD, 1, 1, 1));
    add(0, 0, 0, 0,  1, 16'hA001, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hA001));
    add(0, 0, 0, 0,  1, 16'hA002, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hA002));
    add(0, 0, 0, 0,  1, 16'hA003, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hA003));
    add(0, 0, 0, 0,  1, 16'hA004, 2'b11, 0, 1, 1, mk_bt(TAIL, 1, 16'hA004));
    add(1, 3, 0, 4,  0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEAD, 0, 3, 0));
    add(0, 0, 0, 0,  1, 16'hB001, 2'b10, 0, 0, 0, f0);
    add(0, 0, 0, 0,  1, 16'hB001, 2'b10, 0, 0, 0, f0);
    add(0, 0, 0, 0,  1, 16'hB001, 2'b10, 0, 0, 0, f0);
    add(0, 0, 0, 0,  1, 16'hB001, 2'b11, 0, 1, 1, mk_bt(BODY, 0, 16'hB001));
    add(0, 0, 0, 0,  1, 16'hB002, 2'b11, 0, 1, 1, mk_bt(BODY, 0, 16'hB002));
    add(0, 0, 0, 0,  1, 16'hB003, 2'b11, 0, 1, 1, mk_bt(TAIL, 0, 16'hB003));
    add(1, 4, 5, 1,  0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEADTAIL, 1, 4, 5));
    add(1, 6, 7, 1,  0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEADTAIL, 0, 6, 7));
    add(1, 8, 9, 1,  0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEADTAIL, 1, 8, 9));
    add(1, 1, 2, 1,  0, 16'h0000, 2'b10, 1, 0, 1, mk_head(HEADTAIL, 1, 1, 2));
    add(1, 3, 3, 1,  0, 16'h0000, 2'b00, 0, 0, 0, f0);
    add(1, 5, 5, 0,  0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEADTAIL, 0, 5, 5));
    add(1, 7, 7, 11, 0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEAD, 1, 7, 7));
    add(1, 9, 9, 1,  1, 16'hC000, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hC000));
    add(1, 9, 9, 1,  1, 16'hC001, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hC001));
    add(1, 9, 9, 1,  0, 16'hC002, 2'b11, 0, 1, 0, f0);
    add(1, 9, 9, 1,  1, 16'hC002, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hC002));
    add(1, 9, 9, 1,  1, 16'hC003, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hC003));
    add(1, 9, 9, 1,  1, 16'hC004, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hC004));
    add(1, 9, 9, 1,  1, 16'hC005, 2'b11, 0, 1, 1, mk_bt(BODY, 1, 16'hC005));
    add(1, 9, 9, 1,  1, 16'hC006, 2'b11, 0, 1, 1, mk_bt(TAIL, 1, 16'hC006));
    add(1, 2, 2, 1,  0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEADTAIL, 0, 2, 2));
    add(0, 0, 0, 0,  0, 16'h0000, 2'b11, 1, 0, 0, f0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      run_cycle($sformatf("vec%0d", i), tbl[i]);

    // T6: reset after HEAD and one BODY of a 6-flit packet.
    do_reset();
    add(1, 1, 2, 6, 0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEAD, 0, 1, 2));
    run_cycle("t6_head", tbl[tbl.size()-1]);
    add(0, 0, 0, 0, 1, 16'hD001, 2'b11, 0, 1, 1, mk_bt(BODY, 0, 16'hD001));
    run_cycle("t6_body", tbl[tbl.size()-1]);
    payload_valid = 1'b1;
    payload = 16'hD002;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid_flit", 64'(valid_flit), 64'd0);
    chk("t6_rst_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("t6_rst_payload_ready", 64'(payload_ready), 64'd0);
`ifdef INJECTOR_STATS_EN
    chk("t6_rst_flits_sent", 64'(flits_sent), 64'd0);
    chk("t6_rst_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    add(1, 3, 4, 1, 0, 16'h0000, 2'b11, 1, 0, 1, mk_head(HEADTAIL, 0, 3, 4));
    run_cycle("t6_after", tbl[tbl.size()-1]);

    // Randomized traffic against a packet-level reference model.
    do_reset();
    m_rem = 0; m_vc = 0; m_rr = 0; m_sent = 0; m_stall = 0;
    for (int n = 0; n < 400; n++) begin
      v.pv  = ($urandom_range(0, 3) != 0);
      v.x   = int'($urandom_range(0, 15));
      v.y   = int'($urandom_range(0, 15));
      v.len = int'($urandom_range(0, MAXL + 3));
      v.plv = ($urandom_range(0, 3) != 0);
      v.pl  = 16'($urandom);
      for (int b = 0; b < VC_NUM; b++) v.on[b] = ($urandom_range(0, 3) != 0);
      if (n % 50 == 49) v.on = '0;
      v.e_pr  = (m_rem == 0) && (v.on != '0);
      v.e_plr = (m_rem > 0) && (((v.on >> m_vc) & 1) != 0);
      v.e_v   = 1'b0;
      v.e_f   = '0;
      if (m_rem > 0 && v.plv && !v.e_plr) m_stall++;
      if (v.pv && v.e_pr) begin
        int c, plen;
        c = m_rr;
        for (int k = 0; k < VC_NUM; k++) begin
          c = (m_rr + k) % VC_NUM;
          if (((v.on >> c) & 1) != 0) break;
        end
        plen = (v.len == 0) ? 1 : (v.len > MAXL) ? MAXL : v.len;
        v.e_f = mk_head((plen == 1) ? HEADTAIL : HEAD, c, v.x, v.y);
        v.e_v = 1'b1;
        m_rem = plen - 1;
        m_vc  = c;
        m_rr  = (c + 1) % VC_NUM;
      end else if (v.plv && v.e_plr) begin
        v.e_f = mk_bt((m_rem == 1) ? TAIL : BODY, m_vc, v.pl);
        v.e_v = 1'b1;
        m_rem--;
      end
      if (v.e_v) m_sent++;
      run_cycle($sformatf("rnd%0d", n), v);
    end
    v.pv = 1'b0; v.plv = 1'b0; v.on = '0; v.x = 0; v.y = 0; v.len = 0; v.pl = '0;
    v.e_pr = 1'b0; v.e_plr = 1'b0; v.e_v = 1'b0; v.e_f = '0;
    run_cycle("rnd_drain", v);
`ifdef INJECTOR_STATS_EN
    chk("rnd_flits_sent", 64'(flits_sent), 64'(m_sent));
    chk("rnd_stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    chk("rnd_activity", 64'(m_sent > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
